// File: rtl/sockit_spi_pkg.sv
// Shared constants and FIFO entry type for the SPI receive-side data packer.
package sockit_spi_pkg;

    localparam int SDW = 8;
    localparam int QDW = 32;

    localparam logic [1:0] IOM_3W   = 2'd0;
    localparam logic [1:0] IOM_SPI  = 2'd1;
    localparam logic [1:0] IOM_DUAL = 2'd2;
    localparam logic [1:0] IOM_QUAD = 2'd3;

    localparam int CTL_NEW = 3;
    localparam int CTL_LST = 2;

    typedef struct packed {
        logic [QDW-1:0] dat;
        logic [1:0]     bcn;
        logic           lst;
    } dpk_ent_t;

endpackage

// File: rtl/sockit_spi_dpk_fifo.sv
// Dual-push, single-pop first-word-fall-through FIFO; ent0 is always the older word.
module sockit_spi_dpk_fifo
    import sockit_spi_pkg::*;
#(
    parameter int FFD = 4,
    parameter int FFL = 2
) (
    input  logic           spi_sclk,
    input  logic           rst,
    input  logic [1:0]     push,
    input  dpk_ent_t       ent0,
    input  dpk_ent_t       ent1,
    input  logic           pop,
    output dpk_ent_t       head,
    output logic           empty,
    output logic [FFL:0]   free
);

    logic [FFL:0] wptr, rptr, cnt, wptr1;
    logic         do_pop;
    dpk_ent_t     mem [FFD];

    assign cnt    = wptr - rptr;
    assign empty  = (cnt == '0);
    assign free   = (FFL+1)'(FFD) - cnt;
    assign wptr1  = wptr + (FFL+1)'(1);
    assign do_pop = pop & ~empty;
    // Empty FIFO presents an all-zero entry rather than stale storage.
    assign head   = empty ? '0 : mem[rptr[FFL-1:0]];

    always_ff @(posedge spi_sclk) begin
        if (push != 2'd0) mem[wptr[FFL-1:0]] <= ent0;
        if (push == 2'd2) mem[wptr1[FFL-1:0]] <= ent1;
    end

    always_ff @(posedge spi_sclk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (FFL+1)'(push);
            if (do_pop) rptr <= rptr + (FFL+1)'(1);
        end
    end

endmodule

// File: rtl/sockit_spi_dpk.sv
// SPI receive data packer: lane de-interleave, little-endian word packing, output FIFO.
// Optional byte counter (sts_clr/sts_cnt) enabled by defining SOCKIT_SPI_DPK_CNT_EN.
module sockit_spi_dpk
    import sockit_spi_pkg::*;
#(
    parameter int SDW = 8,
    parameter int QCI = 4,
    parameter int QDW = 32,
    parameter int FFD = 4,
    parameter int FFL = 2
) (
    input  logic           spi_sclk,
    input  logic           rst,
`ifdef SOCKIT_SPI_DPK_CNT_EN
    input  logic           sts_clr,
    output logic [15:0]    sts_cnt,
`endif
    input  logic           qui_req,
    input  logic [QCI-1:0] qui_ctl,
    input  logic [QDW-1:0] qui_dat,
    output logic           qui_grt,
    output logic           pkd_req,
    output logic [QDW-1:0] pkd_dat,
    output logic [1:0]     pkd_bcn,
    output logic           pkd_lst,
    input  logic           pkd_grt
);

    logic [QDW-1:0] acc, acc_base, unit, placed;
    logic [2:0]     acc_cnt, cnt_base, cnt_sum, n;
    logic           xfer, flush, spill, restart, close, empty;
    logic [1:0]     iom, push;
    logic [FFL:0]   free;
    dpk_ent_t       ent_a, ent_b, ent0, head;

    assign iom  = qui_ctl[1:0];
    assign xfer = qui_req & qui_grt;

    always_comb begin
        unit = '0;
        n    = 3'd1;
        case (iom)
            IOM_3W:  unit[SDW-1:0] = qui_dat[0+:SDW];
            IOM_SPI: unit[SDW-1:0] = qui_dat[SDW+:SDW];
            IOM_DUAL: begin
                n = 3'd2;
                for (int k = 0; k < SDW; k++)
                    for (int j = 0; j < 2; j++)
                        unit[2*k+j] = qui_dat[j*SDW+k];
            end
            default: begin
                n = 3'd4;
                for (int k = 0; k < SDW; k++)
                    for (int j = 0; j < 4; j++)
                        unit[4*k+j] = qui_dat[j*SDW+k];
            end
        endcase
    end

    // A new frame or a spill flushes the old partial word; the unit then starts fresh.
    assign flush    = qui_ctl[CTL_NEW] & (acc_cnt != 3'd0);
    assign spill    = ~flush & ((acc_cnt + n) > 3'd4);
    assign restart  = flush | spill;
    assign cnt_base = restart ? 3'd0 : acc_cnt;
    assign acc_base = restart ? '0 : acc;
    assign placed   = acc_base | (unit << {cnt_base, 3'b000});
    assign cnt_sum  = cnt_base + n;
    assign close    = (cnt_sum == 3'd4) | qui_ctl[CTL_LST];

    assign ent_a = '{dat: acc, bcn: 2'(acc_cnt - 3'd1), lst: flush};
    assign ent_b = '{dat: placed, bcn: 2'(cnt_sum - 3'd1), lst: qui_ctl[CTL_LST]};
    assign ent0  = restart ? ent_a : ent_b;
    assign push  = xfer ? ({1'b0, restart} + {1'b0, close}) : 2'd0;

    always_ff @(posedge spi_sclk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_cnt <= 3'd0;
        end else if (xfer) begin
            acc     <= close ? '0 : placed;
            acc_cnt <= close ? 3'd0 : cnt_sum;
        end
    end

    sockit_spi_dpk_fifo #(.FFD(FFD), .FFL(FFL)) u_fifo (
        .spi_sclk (spi_sclk),
        .rst      (rst),
        .push     (push),
        .ent0     (ent0),
        .ent1     (ent_b),
        .pop      (pkd_grt),
        .head     (head),
        .empty    (empty),
        .free     (free)
    );

    assign qui_grt = (free >= (FFL+1)'(2));
    assign pkd_req = ~empty;
    assign pkd_dat = head.dat;
    assign pkd_bcn = head.bcn;
    assign pkd_lst = head.lst;

`ifdef SOCKIT_SPI_DPK_CNT_EN
    logic [15:0] cnt_base16;
    logic [16:0] cnt_next;

    assign cnt_base16 = sts_clr ? 16'd0 : sts_cnt;
    assign cnt_next   = {1'b0, cnt_base16} + 17'(n);

    always_ff @(posedge spi_sclk or posedge rst) begin
        if (rst)
            sts_cnt <= 16'd0;
        else if (xfer)
            sts_cnt <= cnt_next[16] ? 16'hFFFF : cnt_next[15:0];
        else if (sts_clr)
            sts_cnt <= 16'd0;
    end
`endif

endmodule

// File: tb/tb_sockit_spi_dpk.sv
// Randomized and directed check of sockit_spi_dpk against a byte-queue reference model.
module tb_sockit_spi_dpk;

    localparam int FFD = 4;

    logic        spi_sclk = 1'b0;
    logic        rst;
    logic        qui_req;
    logic [3:0]  qui_ctl;
    logic [31:0] qui_dat;
    logic        qui_grt;
    logic        pkd_req;
    logic [31:0] pkd_dat;
    logic [1:0]  pkd_bcn;
    logic        pkd_lst;
    logic        pkd_grt;
`ifdef SOCKIT_SPI_DPK_CNT_EN
    logic        sts_clr;
    logic [15:0] sts_cnt;
`endif

    always #5 spi_sclk = ~spi_sclk;

    sockit_spi_dpk dut (
        .spi_sclk (spi_sclk),
        .rst      (rst),
`ifdef SOCKIT_SPI_DPK_CNT_EN
        .sts_clr  (sts_clr),
        .sts_cnt  (sts_cnt),
`endif
        .qui_req  (qui_req),
        .qui_ctl  (qui_ctl),
        .qui_dat  (qui_dat),
        .qui_grt  (qui_grt),
        .pkd_req  (pkd_req),
        .pkd_dat  (pkd_dat),
        .pkd_bcn  (pkd_bcn),
        .pkd_lst  (pkd_lst),
        .pkd_grt  (pkd_grt)
    );

    typedef struct {
        logic [31:0] dat;
        int          bcn;
        logic        lst;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  acc_q[$];
    int          exp_sts;
    logic        clr_v;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic emit(input logic lst);
        exp_t e;
        e.dat = 32'h0;
        for (int i = 0; i < acc_q.size(); i++) e.dat[8*i+:8] = acc_q[i];
        e.bcn = acc_q.size() - 1;
        e.lst = lst;
        exp_q.push_back(e);
        acc_q.delete();
    endtask

    task automatic model_unit(input logic [3:0] ctl, input logic [31:0] dat);
        logic [31:0] v;
        int          n;
        v = 32'h0;
        case (ctl[1:0])
            2'd0: begin v[7:0] = dat[7:0];  n = 1; end
            2'd1: begin v[7:0] = dat[15:8]; n = 1; end
            2'd2: begin
                n = 2;
                for (int k = 0; k < 8; k++) begin
                    v[2*k+1] = dat[8+k];
                    v[2*k]   = dat[k];
                end
            end
            default: begin
                n = 4;
                for (int k = 0; k < 8; k++)
                    for (int j = 0; j < 4; j++)
                        v[4*k+j] = dat[8*j+k];
            end
        endcase
        if (ctl[3] && acc_q.size() != 0) emit(1'b1);
        if (acc_q.size() + n > 4) emit(1'b0);
        for (int i = 0; i < n; i++) acc_q.push_back(v[8*i+:8]);
        if (acc_q.size() == 4 || ctl[2]) emit(ctl[2]);
        exp_sts = exp_sts + n;
        if (exp_sts > 16'hFFFF) exp_sts = 16'hFFFF;
    endtask

    // One cycle: check outputs at the falling edge, then drive the next inputs
    // and advance the model by the transfers the next rising edge will perform.
    task automatic cyc(input logic req, input logic [3:0] ctl, input logic [31:0] dat, input logic grt);
        @(negedge spi_sclk);
        chk("pkd_req", {31'h0, pkd_req}, {31'h0, exp_q.size() != 0});
        chk("qui_grt", {31'h0, qui_grt}, {31'h0, (FFD - exp_q.size()) >= 2});
        if (exp_q.size() != 0) begin
            chk("pkd_dat", pkd_dat, exp_q[0].dat);
            chk("pkd_bcn", {30'h0, pkd_bcn}, 32'(exp_q[0].bcn));
            chk("pkd_lst", {31'h0, pkd_lst}, {31'h0, exp_q[0].lst});
        end
`ifdef SOCKIT_SPI_DPK_CNT_EN
        chk("sts_cnt", {16'h0, sts_cnt}, 32'(exp_sts));
        sts_clr = clr_v;
        if (clr_v) exp_sts = 0;
`endif
        qui_req = req;
        qui_ctl = ctl;
        qui_dat = dat;
        pkd_grt = grt;
        if (grt && pkd_req && exp_q.size() != 0) void'(exp_q.pop_front());
        if (req && qui_grt) model_unit(ctl, dat);
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 20) begin
            cyc(1'b0, 4'h0, 32'h0, 1'b1);
            i++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'h0);
        idle();
    endtask

    task automatic head(input string tag, input logic [31:0] dat, input logic [1:0] bcn, input logic lst);
        chk({tag, "_dat"}, pkd_dat, dat);
        chk({tag, "_bcn"}, {30'h0, pkd_bcn}, {30'h0, bcn});
        chk({tag, "_lst"}, {31'h0, pkd_lst}, {31'h0, lst});
    endtask

    initial begin
        rst = 1'b1;
        qui_req = 1'b0; qui_ctl = 4'h0; qui_dat = 32'h0; pkd_grt = 1'b0;
        clr_v = 1'b0; exp_sts = 0;
`ifdef SOCKIT_SPI_DPK_CNT_EN
        sts_clr = 1'b0;
`endif
        repeat (2) @(posedge spi_sclk);
        #1;
        chk("rst_pkd_req", {31'h0, pkd_req}, 32'h0);
        chk("rst_qui_grt", {31'h0, qui_grt}, 32'h1);
        chk("rst_pkd_dat", pkd_dat, 32'h0);
        @(negedge spi_sclk);
        rst = 1'b0;

        // Four MISO bytes closed by lst.
        cyc(1, 4'b0001, 32'h0000_1100, 0);
        cyc(1, 4'b0001, 32'h0000_2200, 0);
        cyc(1, 4'b0001, 32'h0000_3300, 0);
        cyc(1, 4'b0101, 32'h0000_4400, 0);
        idle();
        head("t1", 32'h4433_2211, 2'd3, 1'b1);
        drain();

        // Quad unit, then a dual unit held until a closing unit arrives.
        cyc(1, 4'b0011, 32'hFF00_0000, 0);
        idle();
        head("t2q", 32'h8888_8888, 2'd3, 1'b0);
        drain();
        cyc(1, 4'b0010, 32'h0000_FF00, 0);
        idle();
        chk("t2_hold", {31'h0, pkd_req}, 32'h0);
        cyc(1, 4'b0100, 32'h0000_005C, 0);
        idle();
        head("t2d", 32'h005C_AAAA, 2'd2, 1'b1);
        drain();

        // Spill: two words in one cycle.
        cyc(1, 4'b0001, 32'h0000_A100, 0);
        cyc(1, 4'b0001, 32'h0000_A200, 0);
        cyc(1, 4'b0001, 32'h0000_A300, 0);
        cyc(1, 4'b0110, 32'h0000_FF00, 0);
        idle();
        head("t3a", 32'h00A3_A2A1, 2'd2, 1'b0);
        cyc(0, 4'h0, 32'h0, 1);
        idle();
        head("t3b", 32'h0000_AAAA, 2'd1, 1'b1);
        drain();

        // Abandoned frame on new.
        cyc(1, 4'b0001, 32'h0000_0100, 0);
        cyc(1, 4'b0001, 32'h0000_0200, 0);
        cyc(1, 4'b1101, 32'h0000_0500, 0);
        idle();
        head("t4a", 32'h0000_0201, 2'd1, 1'b1);
        cyc(0, 4'h0, 32'h0, 1);
        idle();
        head("t4b", 32'h0000_0005, 2'd0, 1'b1);
        drain();

        // Back-pressure: grant drops once fewer than two entries are free.
        repeat (6) cyc(1, 4'b0011, $urandom, 0);
        idle();
        chk("t5_grt_low", {31'h0, qui_grt}, 32'h0);
        drain();

        // Mid-frame reset: 3 words queued, 2 bytes pending.
        cyc(1, 4'b0011, 32'h1234_5678, 0);
        cyc(1, 4'b0011, 32'h9ABC_DEF0, 0);
        cyc(1, 4'b0001, 32'h0000_B100, 0);
        cyc(1, 4'b0001, 32'h0000_B200, 0);
        cyc(1, 4'b0001, 32'h0000_B300, 0);
        cyc(1, 4'b0010, 32'h0000_0F0F, 0);
        idle();
        chk("t6_qd", 32'(exp_q.size()), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("t6_pkd_req", {31'h0, pkd_req}, 32'h0);
        chk("t6_qui_grt", {31'h0, qui_grt}, 32'h1);
        chk("t6_pkd_dat", pkd_dat, 32'h0);
`ifdef SOCKIT_SPI_DPK_CNT_EN
        chk("t6_sts_cnt", {16'h0, sts_cnt}, 32'h0);
`endif
        exp_q.delete(); acc_q.delete(); exp_sts = 0;
        qui_req = 1'b0; pkd_grt = 1'b0;
        @(negedge spi_sclk);
        rst = 1'b0;
        cyc(1, 4'b0001, 32'h0000_C100, 0);
        cyc(1, 4'b0001, 32'h0000_C200, 0);
        cyc(1, 4'b0001, 32'h0000_C300, 0);
        cyc(1, 4'b0001, 32'h0000_C400, 0);
        idle();
        head("t6_new", 32'hC4C3_C2C1, 2'd3, 1'b0);
        drain();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ctl;
            ctl[3]   = ($urandom_range(15) == 0);
            ctl[2]   = ($urandom_range(3) == 0);
            ctl[1:0] = 2'($urandom_range(3));
            clr_v    = ($urandom_range(63) == 0);
            cyc(($urandom_range(9) < 7), ctl, $urandom, ($urandom_range(1) == 1));
        end
        clr_v = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
